spi_cmd_decoder: RTL and testbench

- Downstream consumer of the SPI peripheral's received-byte stream, in the system clock domain.
- Synchronises the peripheral's byte-ready level and chip-select, then captures each byte.
- Decodes frames of the form [command][data...] into register-file write/read strobes.
- Drives the byte that the peripheral shifts out (its write_data input) for register reads.

---
 rtl/spi_cmd_decoder.sv | 159 +++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// Purpose : decodes SPI frames [command][data...] into register write/read strobes.
// Latency : strobes registered; high SYNC_STAGES+1 edges after rx_ready_in is first sampled high.
// Backpressure: none; bytes arrive at SPI rate, and bytes beyond the frame's access are dropped.
//
// Ports:
//   clock, reset_n                 system clock, async active-low reset
//   chip_select_in, rx_ready_in    asynchronous inputs, each synchronised by SYNC_STAGES flops
//   rx_data_in                     received byte, sampled directly on the synchronised ready edge
//   reg_addr, reg_wr_data          register address / write data, held after a frame ends
//   reg_wr_en, reg_rd_en           one-cycle access strobes, never high together
//   reg_rd_data                    register read data, valid the cycle after reg_rd_en
//   tx_data                        byte presented to the peripheral for shifting out
//   frame_active, frame_error      synchronised chip select / malformed-frame pulse
//
// Optional: define SPI_CMD_AUTOINC_EN for burst accesses with address auto-increment.

module spi_cmd_decoder #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  chip_select_in,
  input  logic                  rx_ready_in,
  input  logic [7:0]            rx_data_in,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wr_data,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [7:0]            reg_rd_data,
  output logic [7:0]            tx_data,
  output logic                  frame_active,
  output logic                  frame_error
);

  // RWAIT covers the cycle where reg_rd_data is not yet valid; RLOAD then captures it.
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RWAIT, RLOAD, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  cs_sync, rdy_sync;
  logic                    rdy_dly;
  logic                    cs_s, rdy_s, byte_evt;

  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [7:0]              wr_data_d, tx_d;
  logic                    wr_en_d, rd_en_d, err_d;

`ifdef SPI_CMD_AUTOINC_EN
  logic                    is_wr_q, is_wr_d;
`endif

  assign cs_s         = cs_sync[SYNC_STAGES-1];
  assign rdy_s        = rdy_sync[SYNC_STAGES-1];
  assign byte_evt     = rdy_s & ~rdy_dly;
  assign frame_active = cs_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync  <= '0;
      rdy_sync <= '0;
      rdy_dly  <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], chip_select_in};
      rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], rx_ready_in};
      rdy_dly  <= rdy_s;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = reg_addr;
    wr_data_d = reg_wr_data;
    tx_d      = tx_data;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    err_d     = 1'b0;
`ifdef SPI_CMD_AUTOINC_EN
    is_wr_d   = is_wr_q;
`endif
    // Deselect overrides everything, including a byte arriving in the same cycle.
    if (state_q != IDLE && !cs_s) begin
      state_d = IDLE;
      err_d   = (state_q == WDATA);
    end else begin
      case (state_q)
        IDLE: if (cs_s) state_d = CMD;
        CMD: begin
          if (byte_evt) begin
            addr_d = rx_data_in[ADDR_WIDTH-1:0];
`ifdef SPI_CMD_AUTOINC_EN
            is_wr_d = rx_data_in[7];
`endif
            if (rx_data_in[7]) begin
              state_d = WDATA;
            end else begin
              rd_en_d = 1'b1;
              state_d = RWAIT;
            end
          end
        end
        WDATA: begin
          if (byte_evt) begin
            wr_data_d = rx_data_in;
            wr_en_d   = 1'b1;
            state_d   = HOLD;
          end
        end
        RWAIT: state_d = RLOAD;
        RLOAD: begin
          tx_d    = reg_rd_data;
          state_d = HOLD;
        end
        HOLD: begin
`ifdef SPI_CMD_AUTOINC_EN
          if (byte_evt) begin
            addr_d = reg_addr + ADDR_WIDTH'(1);
            if (is_wr_q) begin
              wr_data_d = rx_data_in;
              wr_en_d   = 1'b1;
            end else begin
              rd_en_d = 1'b1;
              state_d = RWAIT;
            end
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      tx_data     <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_addr    <= addr_d;
      reg_wr_data <= wr_data_d;
      tx_data     <= tx_d;
      reg_wr_en   <= wr_en_d;
      reg_rd_en   <= rd_en_d;
      frame_error <= err_d;
    end
  end

`ifdef SPI_CMD_AUTOINC_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) is_wr_q <= 1'b0;
    else          is_wr_q <= is_wr_d;
  end
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Purpose : directed self-checking bench for spi_cmd_decoder (default parameters).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a; a small registered read model answers reg_rd_en.

module tb_spi_cmd_decoder;

  logic       clock;
  logic       reset_n;
  logic       chip_select_in;
  logic       rx_ready_in;
  logic [7:0] rx_data_in;
  logic [6:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data;
  logic [7:0] tx_data;
  logic       frame_active;
  logic       frame_error;

  int checks = 0;
  int errors = 0;

  // Pulse counters and write log, maintained only by the monitor below.
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [15:0] wr_log[$];

  spi_cmd_decoder dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .chip_select_in(chip_select_in),
    .rx_ready_in   (rx_ready_in),
    .rx_data_in    (rx_data_in),
    .reg_addr      (reg_addr),
    .reg_wr_data   (reg_wr_data),
    .reg_wr_en     (reg_wr_en),
    .reg_rd_en     (reg_rd_en),
    .reg_rd_data   (reg_rd_data),
    .tx_data       (tx_data),
    .frame_active  (frame_active),
    .frame_error   (frame_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] rd_model(input logic [6:0] a);
    return (a == 7'h12) ? 8'hA7 : {1'b1, a};
  endfunction

  // Register file answers one cycle after the read strobe.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)       reg_rd_data <= 8'h00;
    else if (reg_rd_en) reg_rd_data <= rd_model(reg_addr);
  end

  always @(negedge clock) begin
    if (reg_wr_en) begin
      wr_cnt = wr_cnt + 1;
      wr_log.push_back({1'b0, reg_addr, reg_wr_data});
    end
    if (reg_rd_en)              rd_cnt = rd_cnt + 1;
    if (frame_error)            err_cnt = err_cnt + 1;
    if (reg_wr_en && reg_rd_en) both_cnt = both_cnt + 1;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic start_frame();
    chip_select_in = 1'b1;
    cyc(4);
  endtask

  task automatic end_frame();
    chip_select_in = 1'b0;
    cyc(5);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_in  = b;
    rx_ready_in = 1'b1;
    cyc(4);
    rx_ready_in = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; chip_select_in = 1'b0; rx_ready_in = 1'b0; rx_data_in = 8'h00;
    #2 reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
    checks++;
    if ({reg_addr, reg_wr_data, tx_data, reg_wr_en, reg_rd_en, frame_active, frame_error} !== 30'h0) begin
      errors++;
      $display("FAIL reset_idle: got addr=%h wd=%h tx=%h we=%b re=%b fa=%b fe=%b want all 0",
               reg_addr, reg_wr_data, tx_data, reg_wr_en, reg_rd_en, frame_active, frame_error);
    end
    chip_select_in = 1'b1;
    cyc(1);
    checks++;
    if (frame_active !== 1'b0) begin
      errors++; $display("FAIL cs_sync_early: got %b want 0", frame_active);
    end
    cyc(1);
    checks++;
    if (frame_active !== 1'b1) begin
      errors++; $display("FAIL cs_sync_late: got %b want 1", frame_active);
    end
    end_frame();
  endtask

  task automatic test_write();
    int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
    logic [2:0] seen;
    start_frame();
    send_byte(8'h85);
    rx_data_in  = 8'h3C;
    rx_ready_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      seen[0] = reg_wr_en;
      checks++;
      if (seen[0] !== (i == 3)) begin
        errors++; $display("FAIL wr_latency_edge%0d: got wr_en=%b want %b", i, seen[0], (i == 3));
      end
      if (i == 3) begin
        checks++;
        if ({reg_addr, reg_wr_data} !== {7'h05, 8'h3C}) begin
          errors++; $display("FAIL wr_addr_data: got %h/%h want 05/3c", reg_addr, reg_wr_data);
        end
      end
    end
    rx_ready_in = 1'b0;
    cyc(4);
    end_frame();
    checks++;
    if ((wr_cnt - w0) !== 1 || (rd_cnt - r0) !== 0 || (err_cnt - e0) !== 0) begin
      errors++; $display("FAIL wr_counts: got wr=%0d rd=%0d err=%0d want 1 0 0", wr_cnt - w0, rd_cnt - r0, err_cnt - e0);
    end
    checks++;
    if ({reg_addr, reg_wr_data} !== {7'h05, 8'h3C}) begin
      errors++; $display("FAIL wr_hold_after_frame: got %h/%h want 05/3c", reg_addr, reg_wr_data);
    end
  endtask

  task automatic test_read();
    int w0 = wr_cnt, r0 = rd_cnt;
    start_frame();
    rx_data_in  = 8'h12;
    rx_ready_in = 1'b1;
    cyc(3);
    checks++;
    if (reg_rd_en !== 1'b1 || reg_addr !== 7'h12) begin
      errors++; $display("FAIL rd_strobe: got re=%b addr=%h want 1/12", reg_rd_en, reg_addr);
    end
    cyc(1);
    checks++;
    if (reg_rd_en !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL rd_tx_early: got re=%b tx=%h want 0/00", reg_rd_en, tx_data);
    end
    cyc(1);
    checks++;
    if (tx_data !== 8'hA7) begin
      errors++; $display("FAIL rd_tx_load: got %h want a7", tx_data);
    end
    rx_ready_in = 1'b0;
    cyc(4);
    send_byte(8'h99);
    end_frame();
    checks++;
    if ((rd_cnt - r0) !== 1 || (wr_cnt - w0) !== 0 || tx_data !== 8'hA7) begin
      errors++; $display("FAIL rd_counts: got rd=%0d wr=%0d tx=%h want 1 0 a7", rd_cnt - r0, wr_cnt - w0, tx_data);
    end
  endtask

  task automatic test_abort();
    int w0 = wr_cnt, e0 = err_cnt;
    start_frame();
    send_byte(8'h85);
    end_frame();
    checks++;
    if ((err_cnt - e0) !== 1 || (wr_cnt - w0) !== 0) begin
      errors++; $display("FAIL abort_error: got err=%0d wr=%0d want 1 0", err_cnt - e0, wr_cnt - w0);
    end
    start_frame();
    send_byte(8'h81);
    send_byte(8'h55);
    end_frame();
    checks++;
    if ((wr_cnt - w0) !== 1 || {reg_addr, reg_wr_data} !== {7'h01, 8'h55} || (err_cnt - e0) !== 1) begin
      errors++; $display("FAIL abort_recover: got wr=%0d addr=%h wd=%h err=%0d want 1 01 55 1",
                         wr_cnt - w0, reg_addr, reg_wr_data, err_cnt - e0);
    end
  endtask

  task automatic test_collide();
    int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
    // Collision in CMD: the read command must be dropped, no error.
    start_frame();
    rx_data_in = 8'h23; rx_ready_in = 1'b1; chip_select_in = 1'b0;
    cyc(6);
    rx_ready_in = 1'b0;
    cyc(3);
    checks++;
    if ((rd_cnt - r0) !== 0 || reg_addr !== 7'h01 || (err_cnt - e0) !== 0 || frame_active !== 1'b0) begin
      errors++; $display("FAIL collide_cmd: got rd=%0d addr=%h err=%0d fa=%b want 0 01 0 0",
                         rd_cnt - r0, reg_addr, err_cnt - e0, frame_active);
    end
    // Collision in WDATA: data dropped, frame flagged malformed.
    start_frame();
    send_byte(8'h86);
    rx_data_in = 8'hAA; rx_ready_in = 1'b1; chip_select_in = 1'b0;
    cyc(6);
    rx_ready_in = 1'b0;
    cyc(3);
    checks++;
    if ((wr_cnt - w0) !== 0 || reg_wr_data !== 8'h55 || (err_cnt - e0) !== 1 || reg_addr !== 7'h06) begin
      errors++; $display("FAIL collide_wdata: got wr=%0d wd=%h err=%0d addr=%h want 0 55 1 06",
                         wr_cnt - w0, reg_wr_data, err_cnt - e0, reg_addr);
    end
  endtask

  task automatic test_reset_mid();
    start_frame();
    send_byte(8'h84);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({reg_addr, reg_wr_data, tx_data, reg_wr_en, reg_rd_en, frame_active, frame_error} !== 30'h0) begin
      errors++;
      $display("FAIL reset_mid: got addr=%h wd=%h tx=%h we=%b re=%b fa=%b fe=%b want all 0",
               reg_addr, reg_wr_data, tx_data, reg_wr_en, reg_rd_en, frame_active, frame_error);
    end
    cyc(2);
    chip_select_in = 1'b0;
    reset_n = 1'b1;
    cyc(4);
  endtask

  task automatic test_autoinc();
    int w0 = wr_cnt, e0 = err_cnt;
    int n0 = wr_log.size();
    start_frame();
    send_byte(8'hFF);
    send_byte(8'h01);
    send_byte(8'h02);
    end_frame();
`ifdef SPI_CMD_AUTOINC_EN
    checks++;
    if ((wr_cnt - w0) !== 2 || (err_cnt - e0) !== 0) begin
      errors++; $display("FAIL autoinc_count: got wr=%0d err=%0d want 2 0", wr_cnt - w0, err_cnt - e0);
    end else begin
      checks++;
      if (wr_log[n0] !== 16'h7F01 || wr_log[n0+1] !== 16'h0002) begin
        errors++; $display("FAIL autoinc_wrap: got %h %h want 7f01 0002", wr_log[n0], wr_log[n0+1]);
      end
    end
`else
    checks++;
    if ((wr_cnt - w0) !== 1 || (err_cnt - e0) !== 0) begin
      errors++; $display("FAIL hold_count: got wr=%0d err=%0d want 1 0", wr_cnt - w0, err_cnt - e0);
    end else begin
      checks++;
      if (wr_log[n0] !== 16'h7F01) begin
        errors++; $display("FAIL hold_write: got %h want 7f01", wr_log[n0]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_collide();
    test_reset_mid();
    test_autoinc();
    checks++;
    if (both_cnt !== 0) begin
      errors++; $display("FAIL strobe_overlap: got %0d cycles want 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
